// File: rtl/alu_pkg.sv
// Shared types for the MIPS ALU with its iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLTU  = 4'b0011,
        OP_ANDN  = 4'b0100,
        OP_ORN   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101,
        OP_RSV0  = 4'b1110,
        OP_RSV1  = 4'b1111
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: one result bit per cycle on operand magnitudes,
// signs applied in FIX, then HI/LO loaded and a one-cycle done pulse.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_next;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               launch, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    assign launch = start && is_muldiv(f);
    assign a_neg  = ~f[0] & a[WIDTH-1];
    assign b_neg  = ~f[0] & b[WIDTH-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}; divide:
    // acc = {partial remainder, dividend bits shifting into quotient bits}.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_step  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Divide-by-zero keeps the raw all-ones quotient regardless of operand signs.
    assign prod_fixed = neg_q ? -acc : acc;
    assign quot_fixed = (neg_q && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fixed  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done       = (state == DONE);
                state_next = launch ? (f[1] ? DIV : MUL) : IDLE;
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (count == '0) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            opnd     <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        count    <= CW'(WIDTH - 1);
                        is_div   <= f[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (b == '0);
                        acc      <= {{WIDTH{1'b0}}, f[1] ? mag_a : mag_b};
                        opnd     <= f[1] ? mag_b : mag_a;
                    end
                end
                MUL: begin
                    acc   <= mul_step;
                    count <= count - CW'(1);
                end
                DIV: begin
                    acc   <= div_step;
                    count <= count - CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// MIPS ALU: combinational logic/arithmetic ops plus HI/LO moves, with the
// multiply/divide work delegated to the sequential muldiv_seq engine.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic slt_s, slt_u;

    assign slt_s = $signed(a) < $signed(b);
    assign slt_u = a < b;

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .f       (f),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Mul/div launch codes and the two spare codes read as zero.
    always_comb begin
        y = '0;
        case (alu_op_t'(f))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SLTU: y = WIDTH'(slt_u);
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = WIDTH'(slt_s);
            OP_MFHI: y = hi;
            OP_MFLO: y = lo;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8 against arithmetic reference models.
module tb_alu_muldiv;

    logic        clk;
    logic        reset_n;
    logic [31:0] a, b, y, hi, lo;
    logic [3:0]  f;
    logic        start, zero, busy, done;
    logic [7:0]  a8, b8, y8, hi8, lo8;
    logic [3:0]  f8;
    logic        start8, zero8, busy8, done8;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .f(f), .start(start),
        .y(y), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .a(a8), .b(b8), .f(f8), .start(start8),
        .y(y8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] comb_model(input logic [3:0] op, input logic [31:0] x, yv,
                                               input logic [31:0] h, l);
        case (op)
            4'd0:    return x & yv;
            4'd1:    return x | yv;
            4'd2:    return x + yv;
            4'd3:    return (x < yv) ? 32'd1 : 32'd0;
            4'd4:    return x & ~yv;
            4'd5:    return x | ~yv;
            4'd6:    return x - yv;
            4'd7:    return ($signed(x) < $signed(yv)) ? 32'd1 : 32'd0;
            4'd12:   return h;
            4'd13:   return l;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_md32(input logic [3:0] op, input logic [31:0] x, yv,
                                       output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sx, sy;
        h = '0;
        l = '0;
        case (op)
            4'b1000: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{yv[31]}}, yv});
                h = sp[63:32];
                l = sp[31:0];
            end
            4'b1001: begin
                up = {32'd0, x} * {32'd0, yv};
                h = up[63:32];
                l = up[31:0];
            end
            4'b1010: begin
                sx = $signed(x);
                sy = $signed(yv);
                if (yv == 0) begin
                    l = '1;
                    h = x;
                end else if (x == 32'h8000_0000 && yv == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 0;
                end else begin
                    l = sx / sy;
                    h = sx % sy;
                end
            end
            default: begin
                if (yv == 0) begin
                    l = '1;
                    h = x;
                end else begin
                    l = x / yv;
                    h = x % yv;
                end
            end
        endcase
    endfunction

    function automatic void model_md8(input logic [3:0] op, input logic [7:0] x, yv,
                                      output logic [7:0] h, output logic [7:0] l);
        int p, sx, sy, q, r;
        h = '0;
        l = '0;
        sx = int'($signed(x));
        sy = int'($signed(yv));
        case (op)
            4'b1000: begin
                p = sx * sy;
                h = p[15:8];
                l = p[7:0];
            end
            4'b1001: begin
                p = int'(x) * int'(yv);
                h = p[15:8];
                l = p[7:0];
            end
            4'b1010: begin
                if (yv == 0) begin
                    l = '1;
                    h = x;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[7:0];
                    h = r[7:0];
                end
            end
            default: begin
                if (yv == 0) begin
                    l = '1;
                    h = x;
                end else begin
                    q = int'(x) / int'(yv);
                    r = int'(x) % int'(yv);
                    l = q[7:0];
                    h = r[7:0];
                end
            end
        endcase
    endfunction

    task automatic launch32(input logic [3:0] op, input logic [31:0] opa, opb);
        f = op;
        a = opa;
        b = opb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done32(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic launch8(input logic [3:0] op, input logic [7:0] opa, opb);
        f8 = op;
        a8 = opa;
        b8 = opb;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        a = '0; b = '0; f = '0; start = 1'b0;
        a8 = '0; b8 = '0; f8 = '0; start8 = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_hilo: hi=%h lo=%h expected 0 0", hi, lo);
        end
        f = 4'b0010; a = 32'd5; b = 32'd6;
        #1;
        checks++;
        if (y !== 32'd11 || zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_comb: y=%h zero=%b expected 0000000b 0", y, zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [31:0] expv;
        logic [3:0]  dir_op [4] = '{4'b0010, 4'b0111, 4'b0011, 4'b0110};
        logic [31:0] dir_y  [4] = '{32'd0, 32'd1, 32'd0, 32'hFFFF_FFFE};
        a = 32'hFFFF_FFFF;
        b = 32'd1;
        for (int i = 0; i < 4; i++) begin
            f = dir_op[i];
            #1;
            checks++;
            if (y !== dir_y[i] || zero !== (dir_y[i] == 0)) begin
                errors++;
                $display("[TB] FAIL comb_directed op=%b: y=%h zero=%b expected %h %b",
                         f, y, zero, dir_y[i], dir_y[i] == 0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            #1;
            expv = comb_model(f, a, b, exp_hi, exp_lo);
            checks++;
            if (y !== expv || zero !== (expv == 0)) begin
                errors++;
                $display("[TB] FAIL comb_random op=%b a=%h b=%h: y=%h zero=%b expected %h %b",
                         f, a, b, y, zero, expv, expv == 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc, bcnt;
        launch32(4'b1000, 32'hFFFF_FFFD, 32'd7);
        checks++;
        if (y !== 32'd0 || zero !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mult_inflight: y=%h zero=%b busy=%b expected 0 1 1", y, zero, busy);
        end
        wait_done32(cyc, bcnt);
        checks++;
        if (cyc != 34 || bcnt != 33) begin
            errors++;
            $display("[TB] FAIL mult_latency: done cycle=%0d busy cycles=%0d expected 34 33", cyc, bcnt);
        end
        model_md32(4'b1000, 32'hFFFF_FFFD, 32'd7, exp_hi, exp_lo);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("[TB] FAIL mult_result: hi=%h lo=%h expected ffffffff ffffffeb", hi, lo);
        end
        f = 4'b1101;
        #1;
        checks++;
        if (y !== exp_lo) begin
            errors++;
            $display("[TB] FAIL mflo: y=%h expected %h", y, exp_lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_div();
        int cyc, bcnt;
        logic [3:0]  ops [3] = '{4'b1010, 4'b1011, 4'b1010};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] his [3] = '{32'hFFFF_FFFF, 32'd7, 32'd0};
        logic [31:0] los [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            launch32(ops[i], as[i], bs[i]);
            wait_done32(cyc, bcnt);
            exp_hi = his[i];
            exp_lo = los[i];
            checks++;
            if (cyc != 34 || hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("[TB] FAIL div_directed %0d: cycle=%0d hi=%h lo=%h expected 34 %h %h",
                         i, cyc, hi, lo, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        launch32(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                f = 4'b1010; a = 32'd100; b = 32'd3; start = 1'b1;
            end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'd1;
        checks++;
        if (cyc != 34 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("[TB] FAIL multu_ignore_start: cycle=%0d hi=%h lo=%h expected 34 %h %h",
                     cyc, hi, lo, exp_hi, exp_lo);
        end
        launch32(4'b1000, 32'hFFFF_FFFD, 32'd7);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_relaunch: busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done32(cyc, bcnt);
        model_md32(4'b1000, 32'hFFFF_FFFD, 32'd7, exp_hi, exp_lo);
        checks++;
        if (cyc != 34 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("[TB] FAIL b2b_result: cycle=%0d hi=%h lo=%h expected 34 %h %h",
                     cyc, hi, lo, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int seen;
        launch32(4'b1010, 32'd1000, 32'd7);
        for (int i = 1; i < 10; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet: active cycles=%0d hi=%h lo=%h expected 0 0 0",
                     seen, hi, lo);
        end
    endtask

    task automatic test_width8();
        int cyc;
        logic [7:0] eh, el, ra, rb;
        logic [3:0] op;
        launch8(4'b1000, 8'h80, 8'h80);
        wait_done8(cyc);
        checks++;
        if (cyc != 10 || hi8 !== 8'h40 || lo8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL w8_mult: cycle=%0d hi=%h lo=%h expected 10 40 00", cyc, hi8, lo8);
        end
        @(negedge clk);
        launch8(4'b1010, 8'h80, 8'hFF);
        wait_done8(cyc);
        checks++;
        if (hi8 !== 8'h00 || lo8 !== 8'h80) begin
            errors++;
            $display("[TB] FAIL w8_div_overflow: hi=%h lo=%h expected 00 80", hi8, lo8);
        end
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            op = 4'b1000 | 4'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = (i % 4 == 1) ? 8'd0 : 8'($urandom);
            launch8(op, ra, rb);
            wait_done8(cyc);
            model_md8(op, ra, rb, eh, el);
            checks++;
            if (cyc != 10 || hi8 !== eh || lo8 !== el) begin
                errors++;
                $display("[TB] FAIL w8_random op=%b a=%h b=%h: cycle=%0d hi=%h lo=%h expected 10 %h %h",
                         op, ra, rb, cyc, hi8, lo8, eh, el);
            end
            f8 = 4'b1100;
            #1;
            checks++;
            if (y8 !== eh) begin
                errors++;
                $display("[TB] FAIL w8_mfhi: y=%h expected %h", y8, eh);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int cyc, bcnt;
        logic [31:0] ra, rb;
        logic [3:0]  op;
        for (int i = 0; i < 16; i++) begin
            op = 4'b1000 | 4'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 5 == 0) rb = 32'd0;
            if (i % 7 == 3) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            launch32(op, ra, rb);
            wait_done32(cyc, bcnt);
            model_md32(op, ra, rb, exp_hi, exp_lo);
            checks++;
            if (cyc != 34 || hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("[TB] FAIL md_random op=%b a=%h b=%h: cycle=%0d hi=%h lo=%h expected 34 %h %h",
                         op, ra, rb, cyc, hi, lo, exp_hi, exp_lo);
            end
            f = 4'b1100;
            #1;
            checks++;
            if (y !== exp_hi) begin
                errors++;
                $display("[TB] FAIL mfhi_random: y=%h expected %h", y, exp_hi);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_mult();
        test_div();
        test_back_to_back();
        test_mid_reset();
        test_width8();
        test_random();
        test_comb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
